sum_accumulator: RTL



---
 rtl/sum_accumulator_if.sv | 28 ++
 rtl/sum_accumulator.sv | 81 ++++++++
 2 files changed

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder stage, the sum accumulator and the result consumer.
// The accumulator connects through the slave modport; the stimulus side uses master.
interface sum_accumulator_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] din_data;
  logic                  din_co;
  logic                  din_last;
  logic                  din_vld;
  logic                  din_rd;
  logic [ACC_WIDTH-1:0]  dout_data;
  logic                  dout_overflow;
  logic [CNT_WIDTH-1:0]  dout_cnt;
  logic                  dout_vld;
  logic                  dout_rd;

  modport master (
    output din_data, din_co, din_last, din_vld, dout_rd,
    input  din_rd, dout_data, dout_overflow, dout_cnt, dout_vld
  );

  modport slave (
    input  din_data, din_co, din_last, din_vld, dout_rd,
    output din_rd, dout_data, dout_overflow, dout_cnt, dout_vld
  );
endinterface

// File: rtl/sum_accumulator.sv
// Reduces a stream of adder result words {carry, sum} into one registered frame total,
// word count and sticky wrap flag, presented on a valid/ready result port.
module sum_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_accumulator_if.slave   bus
);
  typedef enum logic {ST_ACC, ST_OUT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  ovf_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  acc_en;
  logic                  clr;
  logic                  rd_state;
  logic                  vld_state;
  logic [ACC_WIDTH:0]    sum;

  // One extra bit captures the carry out of the accumulator's top bit.
  assign sum = {1'b0, acc_q} + (ACC_WIDTH+1)'({bus.din_co, bus.din_data});

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_state  = 1'b0;
    vld_state = 1'b0;
    acc_en    = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      ST_ACC: begin
        rd_state = 1'b1;
        if (bus.din_vld) begin
          acc_en = 1'b1;
          if (bus.din_last) state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        vld_state = 1'b1;
        if (bus.dout_rd) begin
          clr     = 1'b1;
          state_d = ST_ACC;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc_en) begin
        acc_q <= sum[ACC_WIDTH-1:0];
        ovf_q <= ovf_q | sum[ACC_WIDTH];
        cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      end else if (clr) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        cnt_q <= '0;
      end
    end
  end

  // Ready is held low for the whole time reset is asserted, not only until the next edge.
  assign bus.din_rd        = rd_state & rst_n;
  assign bus.dout_vld      = vld_state;
  assign bus.dout_data     = acc_q;
  assign bus.dout_overflow = ovf_q;
  assign bus.dout_cnt      = cnt_q;
endmodule
